// File: rtl/uart_reg_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : uart_reg_bridge
//  Purpose  : Command engine between the UART FIFOs and a simple register
//             bus. Decodes single-byte-opcode read/write frames popped from
//             the RX FIFO, performs the register access and pushes exactly
//             one response byte per frame into the TX FIFO.
//  Ports    : clk, reset           - clock, asynchronous active-high reset
//             rx_empty, r_data,    - RX FIFO head and pop strobe
//             rd_uart
//             tx_full, w_data,     - TX FIFO status, data and push strobe
//             wr_uart
//             reg_addr, reg_wdata, - register bus (1-cycle strobes, read
//             reg_we, reg_re,        data sampled 1 cycle after reg_re)
//             reg_rdata
//             busy                 - high whenever a frame is in progress
//  Revision : 1.0 - initial release
// ============================================================================
module uart_reg_bridge #(
    parameter int         NREG    = 8,
    parameter int         TIMEOUT = 50000000,
    parameter int         TO_BIT  = 26,
    parameter logic [7:0] OP_RD   = 8'h52,
    parameter logic [7:0] OP_WR   = 8'h57,
    parameter logic [7:0] ACK     = 8'h06,
    parameter logic [7:0] NAK     = 8'h15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    output logic       rd_uart,
    input  logic       tx_full,
    output logic [7:0] w_data,
    output logic       wr_uart,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    localparam logic [8:0]        c_nreg    = 9'(NREG);
    localparam logic [TO_BIT-1:0] c_to_last = TO_BIT'(TIMEOUT - 1);
    localparam logic [TO_BIT-1:0] c_to_one  = TO_BIT'(1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_GET_ADDR   = 3'd1,
        S_GET_DATA   = 3'd2,
        S_RD_STROBE  = 3'd3,
        S_RD_CAPTURE = 3'd4,
        S_WR_STROBE  = 3'd5,
        S_SEND       = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_is_wr;
    logic              w_is_wr_nxt;
    logic [7:0]        r_w_data;
    logic [7:0]        w_w_data_nxt;
    logic              r_wr_uart;
    logic              w_wr_uart_nxt;
    logic [7:0]        r_reg_addr;
    logic [7:0]        w_reg_addr_nxt;
    logic [7:0]        r_reg_wdata;
    logic [7:0]        w_reg_wdata_nxt;
    logic              r_reg_we;
    logic              r_reg_re;
    logic              r_busy;
    logic [TO_BIT-1:0] r_to_cnt;
    logic [TO_BIT-1:0] w_to_cnt_nxt;

    logic w_rx_state;
    logic w_pop;
    logic w_waiting;
    logic w_timeout;
    logic w_addr_bad;

    // Bytes are only consumed while the engine is collecting a frame.
    assign w_rx_state = (r_state == S_IDLE) || (r_state == S_GET_ADDR) ||
                        (r_state == S_GET_DATA);
    assign w_pop      = ~reset & ~rx_empty & w_rx_state;
    assign w_waiting  = (r_state == S_GET_ADDR) || (r_state == S_GET_DATA);
    assign w_timeout  = (r_to_cnt == c_to_last);
    assign w_addr_bad = ({1'b0, r_data} >= c_nreg);

    always_comb begin
        w_state_nxt     = r_state;
        w_is_wr_nxt     = r_is_wr;
        w_w_data_nxt    = r_w_data;
        w_wr_uart_nxt   = 1'b0;
        w_reg_addr_nxt  = r_reg_addr;
        w_reg_wdata_nxt = r_reg_wdata;

        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    if (r_data == OP_RD) begin
                        w_state_nxt = S_GET_ADDR;
                        w_is_wr_nxt = 1'b0;
                    end else if (r_data == OP_WR) begin
                        w_state_nxt = S_GET_ADDR;
                        w_is_wr_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = S_SEND;
                        w_w_data_nxt = NAK;
                    end
                end
            end
            S_GET_ADDR: begin
                // A pop in the timeout cycle wins over the timeout.
                if (w_pop) begin
                    w_reg_addr_nxt = r_data;
                    if (w_addr_bad) begin
                        // The data byte of a rejected write stays in the
                        // FIFO and is decoded as the next opcode.
                        w_state_nxt  = S_SEND;
                        w_w_data_nxt = NAK;
                    end else if (r_is_wr) begin
                        w_state_nxt = S_GET_DATA;
                    end else begin
                        w_state_nxt = S_RD_STROBE;
                    end
                end else if (w_timeout) begin
                    w_state_nxt  = S_SEND;
                    w_w_data_nxt = NAK;
                end
            end
            S_GET_DATA: begin
                if (w_pop) begin
                    w_reg_wdata_nxt = r_data;
                    w_state_nxt     = S_WR_STROBE;
                end else if (w_timeout) begin
                    w_state_nxt  = S_SEND;
                    w_w_data_nxt = NAK;
                end
            end
            S_WR_STROBE: begin
                w_w_data_nxt = ACK;
                w_state_nxt  = S_SEND;
            end
            S_RD_STROBE: begin
                w_state_nxt = S_RD_CAPTURE;
            end
            S_RD_CAPTURE: begin
                w_w_data_nxt = reg_rdata;
                w_state_nxt  = S_SEND;
            end
            S_SEND: begin
                if (!tx_full) begin
                    w_wr_uart_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Inter-byte timer: restarted by every pop (which also covers entry to
    // GET_ADDR), advanced only while waiting on an empty FIFO.
    always_comb begin
        w_to_cnt_nxt = r_to_cnt;
        if (w_pop) begin
            w_to_cnt_nxt = '0;
        end else if (w_waiting && rx_empty) begin
            w_to_cnt_nxt = r_to_cnt + c_to_one;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_is_wr     <= 1'b0;
            r_w_data    <= 8'h00;
            r_wr_uart   <= 1'b0;
            r_reg_addr  <= 8'h00;
            r_reg_wdata <= 8'h00;
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_busy      <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_is_wr     <= w_is_wr_nxt;
            r_w_data    <= w_w_data_nxt;
            r_wr_uart   <= w_wr_uart_nxt;
            r_reg_addr  <= w_reg_addr_nxt;
            r_reg_wdata <= w_reg_wdata_nxt;
            // Strobes are registered from the next state so they are high
            // exactly during the single STROBE-state cycle.
            r_reg_we    <= (w_state_nxt == S_WR_STROBE);
            r_reg_re    <= (w_state_nxt == S_RD_STROBE);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_to_cnt    <= w_to_cnt_nxt;
        end
    end

    assign rd_uart   = w_pop;
    assign w_data    = r_w_data;
    assign wr_uart   = r_wr_uart;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_reg_wdata;
    assign reg_we    = r_reg_we;
    assign reg_re    = r_reg_re;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_reg_bridge
//  Purpose  : Self-checking bench for uart_reg_bridge. Models the RX FIFO,
//             TX FIFO sink and a register file, and predicts responses with
//             a frame-level reference model of the command protocol.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_reg_bridge;

    localparam int         c_nreg    = 8;
    localparam int         c_timeout = 100;
    localparam logic [7:0] c_op_rd   = 8'h52;
    localparam logic [7:0] c_op_wr   = 8'h57;
    localparam logic [7:0] c_ack     = 8'h06;
    localparam logic [7:0] c_nak     = 8'h15;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       tx_full  = 1'b0;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic [7:0] w_data;
    logic       wr_uart;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;

    int checks = 0;
    int errors = 0;

    uart_reg_bridge #(
        .NREG    (c_nreg),
        .TIMEOUT (c_timeout),
        .TO_BIT  (8),
        .OP_RD   (c_op_rd),
        .OP_WR   (c_op_wr),
        .ACK     (c_ack),
        .NAK     (c_nak)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_empty  (rx_empty),
        .r_data    (r_data),
        .rd_uart   (rd_uart),
        .tx_full   (tx_full),
        .w_data    (w_data),
        .wr_uart   (wr_uart),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ---------------- environment: FIFOs, register file, monitors ----------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] rx_mem [0:1023];
    int rx_wp = 0;
    int rx_rp = 0;
    int pop_cnt = 0;
    int pop_bad = 0;
    int last_pop_cyc = 0;
    assign rx_empty = (rx_wp == rx_rp);
    assign r_data   = rx_mem[rx_rp[9:0]];

    always @(posedge clk) begin
        if (rd_uart) begin
            if (rx_wp == rx_rp) pop_bad <= pop_bad + 1;
            rx_rp        <= rx_rp + 1;
            pop_cnt      <= pop_cnt + 1;
            last_pop_cyc <= cyc;
        end
    end

    logic [7:0] tx_log [0:511];
    int         tx_cyc [0:511];
    int         tx_cnt = 0;
    always @(posedge clk) begin
        if (wr_uart) begin
            tx_log[tx_cnt] <= w_data;
            tx_cyc[tx_cnt] <= cyc;
            tx_cnt         <= tx_cnt + 1;
        end
    end

    function automatic logic [7:0] init_val(input int a);
        return 8'(8'hA2 + a);
    endfunction

    logic [7:0]   reg_mem [0:255];
    logic [255:0] reg_wr_flags = '0;
    int           we_cnt = 0;
    int           re_cnt = 0;
    int           strobe_bad = 0;
    logic [7:0]   last_re_addr = 8'h00;
    logic [7:0]   last_we_addr = 8'h00;
    logic [7:0]   last_we_data = 8'h00;
    logic         prev_we = 1'b0;
    logic         prev_re = 1'b0;

    always @(posedge clk) begin
        if (reg_re) begin
            reg_rdata    <= reg_wr_flags[reg_addr] ? reg_mem[reg_addr] : init_val(int'(reg_addr));
            re_cnt       <= re_cnt + 1;
            last_re_addr <= reg_addr;
        end
        if (reg_we) begin
            reg_mem[reg_addr]      <= reg_wdata;
            reg_wr_flags[reg_addr] <= 1'b1;
            we_cnt                 <= we_cnt + 1;
            last_we_addr           <= reg_addr;
            last_we_data           <= reg_wdata;
        end
        if ((reg_we && reg_re) || (reg_we && prev_we) || (reg_re && prev_re))
            strobe_bad <= strobe_bad + 1;
        prev_we <= reg_we;
        prev_re <= reg_re;
    end

    function automatic logic [7:0] bus_val(input int a);
        return reg_wr_flags[a] ? reg_mem[a] : init_val(a);
    endfunction

    // ---------------- frame-level reference model --------------------------
    logic [7:0] model_mem [0:255];
    logic [7:0] m_in  [$];
    logic [7:0] m_exp [$];
    int         m_writes = 0;

    // Walks the byte stream frame by frame: an opcode, then an address, then
    // (writes only) a data byte. A bad address ends the frame at once.
    task automatic model_run();
        int i = 0;
        logic [7:0] op;
        logic [7:0] a;
        m_exp.delete();
        while (i < m_in.size()) begin
            op = m_in[i];
            i++;
            if (op != c_op_rd && op != c_op_wr) begin
                m_exp.push_back(c_nak);
            end else if (i < m_in.size()) begin
                a = m_in[i];
                i++;
                if (int'(a) >= c_nreg) begin
                    m_exp.push_back(c_nak);
                end else if (op == c_op_rd) begin
                    m_exp.push_back(model_mem[a]);
                end else if (i < m_in.size()) begin
                    model_mem[a] = m_in[i];
                    i++;
                    m_writes++;
                    m_exp.push_back(c_ack);
                end
            end
        end
        m_in.delete();
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_mem[rx_wp[9:0]] = b;
        rx_wp = rx_wp + 1;
    endtask

    task automatic send(input logic [7:0] b);
        push_byte(b);
        m_in.push_back(b);
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < budget) begin
            @(negedge clk);
            if (rx_wp == rx_rp && !busy && !wr_uart) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        @(negedge clk);
    endtask

    task automatic wait_rx_empty(input int budget, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < budget) begin
            @(negedge clk);
            if (rx_wp == rx_rp) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
    endtask

    // ---------------- tests ------------------------------------------------
    task automatic test_reset();
        reset   = 1'b1;
        tx_full = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, wr_uart, reg_we, reg_re, rd_uart} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 00000", {busy, wr_uart, reg_we, reg_re, rd_uart});
        end
        checks++;
        if ({w_data, reg_addr, reg_wdata} !== 24'h0) begin
            errors++;
            $display("FAIL reset_data got %h exp 000000", {w_data, reg_addr, reg_wdata});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx_cnt !== 0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b tx=%0d exp busy=0 tx=0", busy, tx_cnt);
        end
    endtask

    task automatic test_read();
        int base = tx_cnt;
        int re0 = re_cnt;
        int we0 = we_cnt;
        bit ok;
        @(negedge clk);
        send(c_op_rd);
        send(8'h03);
        model_run();
        wait_drain(200, ok);
        checks++;
        if (!ok || tx_cnt - base !== 1) begin
            errors++;
            $display("FAIL read_count got %0d exp 1 (drained=%0d)", tx_cnt - base, ok);
        end
        checks++;
        if (tx_log[base] !== 8'hA5) begin
            errors++;
            $display("FAIL read_data got %h exp a5", tx_log[base]);
        end
        checks++;
        if (re_cnt - re0 !== 1 || last_re_addr !== 8'h03 || we_cnt !== we0) begin
            errors++;
            $display("FAIL read_bus got re=%0d addr=%h we=%0d exp re=1 addr=03 we=0",
                     re_cnt - re0, last_re_addr, we_cnt - we0);
        end
    endtask

    task automatic test_write();
        int base = tx_cnt;
        int we0 = we_cnt;
        bit ok;
        @(negedge clk);
        send(c_op_wr);
        send(8'h02);
        send(8'h3C);
        model_run();
        wait_drain(200, ok);
        checks++;
        if (!ok || tx_cnt - base !== 1 || tx_log[base] !== c_ack) begin
            errors++;
            $display("FAIL write_resp got n=%0d byte=%h exp n=1 byte=06", tx_cnt - base, tx_log[base]);
        end
        checks++;
        if (we_cnt - we0 !== 1 || last_we_addr !== 8'h02 || last_we_data !== 8'h3C) begin
            errors++;
            $display("FAIL write_bus got we=%0d addr=%h data=%h exp we=1 addr=02 data=3c",
                     we_cnt - we0, last_we_addr, last_we_data);
        end
        checks++;
        if (busy !== 1'b0 || bus_val(2) !== 8'h3C) begin
            errors++;
            $display("FAIL write_after got busy=%b reg2=%h exp busy=0 reg2=3c", busy, bus_val(2));
        end
    endtask

    task automatic test_errors();
        int base = tx_cnt;
        int re0 = re_cnt;
        int we0 = we_cnt;
        bit ok;
        @(negedge clk);
        send(8'h41);
        send(c_op_rd); send(8'h09);
        send(c_op_wr); send(8'h08); send(c_op_rd); send(8'h01);
        model_run();
        wait_drain(400, ok);
        checks++;
        if (!ok || tx_cnt - base !== m_exp.size()) begin
            errors++;
            $display("FAIL err_count got %0d exp %0d", tx_cnt - base, m_exp.size());
        end
        for (int k = 0; k < m_exp.size(); k++) begin
            checks++;
            if (tx_log[base + k] !== m_exp[k]) begin
                errors++;
                $display("FAIL err_resp[%0d] got %h exp %h", k, tx_log[base + k], m_exp[k]);
            end
        end
        checks++;
        if (re_cnt - re0 !== 1 || last_re_addr !== 8'h01 || we_cnt !== we0) begin
            errors++;
            $display("FAIL err_bus got re=%0d addr=%h we=%0d exp re=1 addr=01 we=0",
                     re_cnt - re0, last_re_addr, we_cnt - we0);
        end
    endtask

    task automatic test_timeout();
        int base = tx_cnt;
        int we0 = we_cnt;
        int n = 0;
        logic [7:0] d;
        bit ok;
        @(negedge clk);
        push_byte(c_op_wr);
        push_byte(8'h01);
        wait_drain(3 * c_timeout, ok);
        // Last pop in cycle P; counter reaches TIMEOUT-1 in cycle P+TIMEOUT,
        // one SEND cycle follows, and the registered push lands one later.
        checks++;
        if (!ok || tx_cnt - base !== 1 || tx_log[base] !== c_nak) begin
            errors++;
            $display("FAIL timeout_resp got n=%0d byte=%h exp n=1 byte=15", tx_cnt - base, tx_log[base]);
        end
        checks++;
        if (tx_cyc[base] - last_pop_cyc !== c_timeout + 2 || we_cnt !== we0) begin
            errors++;
            $display("FAIL timeout_lat got %0d we=%0d exp %0d we=0",
                     tx_cyc[base] - last_pop_cyc, we_cnt - we0, c_timeout + 2);
        end
        // Data byte arriving in the cycle before the deadline is accepted.
        base = tx_cnt;
        d = 8'($urandom_range(0, 255));
        push_byte(c_op_wr);
        push_byte(8'h01);
        wait_rx_empty(50, ok);
        while (cyc < last_pop_cyc + c_timeout - 1 && n < 2 * c_timeout) begin
            @(negedge clk);
            n++;
        end
        push_byte(d);
        model_mem[1] = d;
        wait_drain(200, ok);
        checks++;
        if (!ok || tx_cnt - base !== 1 || tx_log[base] !== c_ack || bus_val(1) !== d) begin
            errors++;
            $display("FAIL timeout_late got n=%0d byte=%h reg1=%h exp n=1 byte=06 reg1=%h",
                     tx_cnt - base, tx_log[base], bus_val(1), d);
        end
    endtask

    task automatic test_backpressure();
        int base = tx_cnt;
        int we0 = we_cnt;
        int pops0;
        bit ok;
        @(negedge clk);
        tx_full = 1'b1;
        send(c_op_wr); send(8'h06); send(8'h5A);
        wait_rx_empty(50, ok);
        repeat (2) @(negedge clk);
        send(8'h41);
        pops0 = pop_cnt;
        repeat (20) @(negedge clk);
        checks++;
        if (tx_cnt !== base || pop_cnt !== pops0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold got tx=%0d pops=%0d busy=%b exp tx=0 pops=0 busy=1",
                     tx_cnt - base, pop_cnt - pops0, busy);
        end
        tx_full = 1'b0;
        model_run();
        wait_drain(200, ok);
        checks++;
        if (!ok || tx_cnt - base !== 2 || tx_log[base] !== m_exp[0] || tx_log[base + 1] !== m_exp[1]) begin
            errors++;
            $display("FAIL bp_resp got n=%0d %h %h exp n=2 %h %h",
                     tx_cnt - base, tx_log[base], tx_log[base + 1], m_exp[0], m_exp[1]);
        end
        checks++;
        if (we_cnt - we0 !== 1 || bus_val(6) !== 8'h5A) begin
            errors++;
            $display("FAIL bp_write got we=%0d reg6=%h exp we=1 reg6=5a", we_cnt - we0, bus_val(6));
        end
    endtask

    task automatic test_reset_mid();
        int base = tx_cnt;
        int we0 = we_cnt;
        bit ok;
        @(negedge clk);
        push_byte(c_op_wr);
        push_byte(8'h05);
        wait_rx_empty(50, ok);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy got %b exp 1", busy);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, wr_uart, reg_we, reg_re, rd_uart, w_data, reg_addr, reg_wdata} !== 29'h0) begin
            errors++;
            $display("FAIL mid_reset got %h exp 0",
                     {busy, wr_uart, reg_we, reg_re, rd_uart, w_data, reg_addr, reg_wdata});
        end
        @(negedge clk);
        send(c_op_rd);
        #1;
        checks++;
        if (rd_uart !== 1'b0) begin
            errors++;
            $display("FAIL mid_pop got %b exp 0", rd_uart);
        end
        @(negedge clk);
        reset = 1'b0;
        send(8'h05);
        model_run();
        wait_drain(200, ok);
        checks++;
        if (!ok || tx_cnt - base !== 1 || tx_log[base] !== m_exp[0] || we_cnt !== we0) begin
            errors++;
            $display("FAIL mid_after got n=%0d byte=%h we=%0d exp n=1 byte=%h we=0",
                     tx_cnt - base, tx_log[base], we_cnt - we0, m_exp[0]);
        end
    endtask

    task automatic test_back_to_back();
        int base = tx_cnt;
        bit ok;
        @(negedge clk);
        send(c_op_rd); send(8'h00);
        send(c_op_wr); send(8'h04); send(8'h11);
        send(c_op_rd); send(8'h04);
        model_run();
        wait_drain(200, ok);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (tx_log[base + k] !== m_exp[k]) begin
                errors++;
                $display("FAIL b2b_resp[%0d] got %h exp %h", k, tx_log[base + k], m_exp[k]);
            end
        end
        // Each read or write frame occupies exactly five cycles pop-to-pop.
        checks++;
        if (!ok || tx_cnt - base !== 3 || tx_cyc[base + 1] - tx_cyc[base] !== 5 ||
            tx_cyc[base + 2] - tx_cyc[base + 1] !== 5) begin
            errors++;
            $display("FAIL b2b_gap got n=%0d gaps %0d %0d exp n=3 gaps 5 5", tx_cnt - base,
                     tx_cyc[base + 1] - tx_cyc[base], tx_cyc[base + 2] - tx_cyc[base + 1]);
        end
    endtask

    task automatic test_random();
        int base = tx_cnt;
        int we0 = we_cnt;
        int w0 = m_writes;
        logic [7:0] fr [$];
        logic [7:0] b;
        int k;
        bit ok;
        @(negedge clk);
        for (int f = 0; f < 40; f++) begin
            fr.delete();
            k = $urandom_range(0, 9);
            if (k == 0) begin
                b = 8'($urandom_range(0, 255));
                if (b == c_op_rd || b == c_op_wr) b = 8'h00;
                fr.push_back(b);
            end else if (k == 1) begin
                fr.push_back(c_op_rd);
                fr.push_back(8'($urandom_range(c_nreg, 255)));
            end else if (k == 2) begin
                fr.push_back(c_op_wr);
                fr.push_back(8'($urandom_range(c_nreg, 255)));
            end else if (k <= 5) begin
                fr.push_back(c_op_rd);
                fr.push_back(8'($urandom_range(0, c_nreg - 1)));
            end else begin
                fr.push_back(c_op_wr);
                fr.push_back(8'($urandom_range(0, c_nreg - 1)));
                fr.push_back(8'($urandom_range(0, 255)));
            end
            foreach (fr[j]) begin
                repeat ($urandom_range(0, 4)) begin
                    @(negedge clk);
                    tx_full = ($urandom_range(0, 3) == 0);
                end
                send(fr[j]);
            end
        end
        @(negedge clk);
        tx_full = 1'b0;
        model_run();
        wait_drain(3000, ok);
        checks++;
        if (!ok || tx_cnt - base !== m_exp.size()) begin
            errors++;
            $display("FAIL rand_count got %0d exp %0d", tx_cnt - base, m_exp.size());
        end
        for (int j = 0; j < m_exp.size(); j++) begin
            checks++;
            if (tx_log[base + j] !== m_exp[j]) begin
                errors++;
                $display("FAIL rand_resp[%0d] got %h exp %h", j, tx_log[base + j], m_exp[j]);
            end
        end
        for (int a = 0; a < c_nreg; a++) begin
            checks++;
            if (bus_val(a) !== model_mem[a]) begin
                errors++;
                $display("FAIL rand_reg[%0d] got %h exp %h", a, bus_val(a), model_mem[a]);
            end
        end
        checks++;
        if (we_cnt - we0 !== m_writes - w0) begin
            errors++;
            $display("FAIL rand_writes got %0d exp %0d", we_cnt - we0, m_writes - w0);
        end
    endtask

    task automatic test_bus_rules();
        checks++;
        if (strobe_bad !== 0 || pop_bad !== 0) begin
            errors++;
            $display("FAIL bus_rules got strobe=%0d pop=%0d exp 0 0", strobe_bad, pop_bad);
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) model_mem[a] = init_val(a);
        test_reset();
        test_read();
        test_write();
        test_errors();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_bus_rules();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
